// File: rtl/kara_pkg.sv
// Shared types and elaboration-time helpers for the serial Karatsuba multiplier.
package kara_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_MUL_LO  = 3'd2,
    ST_MUL_HI  = 3'd3,
    ST_MUL_MID = 3'd4,
    ST_COMBINE = 3'd5,
    ST_HOLD    = 3'd6
  } kara_state_t;

  localparam int KARA_OP_W_DEF  = 64;
  localparam int KARA_DIG_W_DEF = 4;

  // beats per frame
  function automatic int kara_beats(input int op_w, input int dig_w);
    return op_w / dig_w;
  endfunction

  // half operand width used by the Karatsuba split
  function automatic int kara_half(input int op_w);
    return op_w / 2;
  endfunction

  // digit counter must hold values 0..N inclusive
  function automatic int kara_cnt_w(input int op_w, input int dig_w);
    return $clog2(op_w / dig_w + 1);
  endfunction

  // operands must split into two halves made of whole digits
  function automatic bit kara_params_ok(input int op_w, input int dig_w);
    return (dig_w > 0) && (op_w > 0) && ((op_w % (2 * dig_w)) == 0);
  endfunction

  localparam int KARA_N_DEF     = kara_beats(KARA_OP_W_DEF, KARA_DIG_W_DEF);
  localparam int KARA_H_DEF     = kara_half(KARA_OP_W_DEF);
  localparam int KARA_CNT_W_DEF = kara_cnt_w(KARA_OP_W_DEF, KARA_DIG_W_DEF);

endpackage

// File: rtl/kara_half_mul.sv
// Unsigned W x W multiplier with a registered product (one-cycle latency).
module kara_half_mul #(
  parameter int W = 33
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  // register the full-width product of the current operands
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/kara_serial_mult.sv
// Digit-serial operand capture followed by a one-level Karatsuba product
// using a single time-shared (H+1)-bit multiplier.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | waiting for a beat carrying start
//   COLLECT    | shifting in digits 1..N-1 (start restarts the frame)
//   MUL_LO     | multiplier fed aL*bL
//   MUL_HI     | z0 captured, multiplier fed aH*bH
//   MUL_MID    | z2 captured, multiplier fed (aL+aH)*(bL+bH)
//   COMBINE    | phase 0: z1 = zm-z0-z2; phase 1: Data_out assembled
//   HOLD       | Data_out valid, waiting for out_ready
module kara_serial_mult
  import kara_pkg::*;
#(
  parameter int OP_W  = KARA_OP_W_DEF,
  parameter int DIG_W = KARA_DIG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIG_W-1:0]  Data_in1,
  input  logic [DIG_W-1:0]  Data_in2,
  output logic [2*OP_W-1:0] Data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              framing_err
);

  localparam int N     = kara_beats(OP_W, DIG_W);
  localparam int H     = kara_half(OP_W);
  localparam int CNT_W = kara_cnt_w(OP_W, DIG_W);
  localparam int PW    = 2 * H + 2;
  localparam int DW    = 2 * OP_W;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  if (!kara_params_ok(OP_W, DIG_W)) begin : g_param_check
    $error("kara_serial_mult: OP_W must be a non-zero multiple of 2*DIG_W");
  end

  kara_state_t      state, state_nxt;
  logic             beat;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [OP_W-1:0]  op_a, op_b;
  logic [H:0]       mul_a, mul_b;
  logic [PW-1:0]    mul_p;
  logic [PW-1:0]    z0, z1, z2;
  logic             comb_ph;
  logic [DW-1:0]    z0_w, z1_w, z2_w, prod_w;

  assign in_ready = (state == ST_IDLE) || (state == ST_COLLECT);
  assign busy     = (state != ST_IDLE);
  assign beat     = in_valid && in_ready;
  assign cnt_nxt  = start ? CNT_W'(1) : cnt + CNT_W'(1);

  // final recombination; the sum is exact within 2*OP_W bits
  assign z0_w   = DW'(z0);
  assign z1_w   = DW'(z1);
  assign z2_w   = DW'(z2);
  assign prod_w = (z2_w << OP_W) + (z1_w << H) + z0_w;

  kara_half_mul #(
    .W (H + 1)
  ) u_half_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode and multiplier operand selection
  always_comb begin
    state_nxt = state;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      ST_IDLE: begin
        if (beat && start) begin
          state_nxt = (cnt_nxt == N_CNT) ? ST_MUL_LO : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (beat && (cnt_nxt == N_CNT)) begin
          state_nxt = ST_MUL_LO;
        end
      end
      ST_MUL_LO: begin
        mul_a     = {1'b0, op_a[H-1:0]};
        mul_b     = {1'b0, op_b[H-1:0]};
        state_nxt = ST_MUL_HI;
      end
      ST_MUL_HI: begin
        mul_a     = {1'b0, op_a[OP_W-1:H]};
        mul_b     = {1'b0, op_b[OP_W-1:H]};
        state_nxt = ST_MUL_MID;
      end
      ST_MUL_MID: begin
        mul_a     = {1'b0, op_a[H-1:0]} + {1'b0, op_a[OP_W-1:H]};
        mul_b     = {1'b0, op_b[H-1:0]} + {1'b0, op_b[OP_W-1:H]};
        state_nxt = ST_COMBINE;
      end
      ST_COMBINE: begin
        if (comb_ph) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // operand capture, partial-product registers and output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      cnt         <= '0;
      z0          <= '0;
      z1          <= '0;
      z2          <= '0;
      comb_ph     <= 1'b0;
      Data_out    <= '0;
      out_valid   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= (state == ST_IDLE) && beat && !start;

      // a start beat discards any partial frame and begins again at digit 0
      if (beat && (start || (state == ST_COLLECT))) begin
        op_a <= start ? OP_W'(Data_in1) : {op_a[OP_W-DIG_W-1:0], Data_in1};
        op_b <= start ? OP_W'(Data_in2) : {op_b[OP_W-DIG_W-1:0], Data_in2};
        cnt  <= cnt_nxt;
      end

      case (state)
        ST_MUL_HI:  z0 <= mul_p;
        ST_MUL_MID: z2 <= mul_p;
        ST_COMBINE: begin
          // the wide subtract and the wide add are split over two cycles
          if (!comb_ph) begin
            z1      <= mul_p - z0 - z2;
            comb_ph <= 1'b1;
          end else begin
            Data_out  <= prod_w;
            out_valid <= 1'b1;
            comb_ph   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kara_serial_mult.sv
// Directed bench for kara_serial_mult: default 64/4 instance plus a 32/8 variant.
module tb_kara_serial_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 64-bit / 4-bit-digit instance
  logic         start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]   d1 = '0, d2 = '0;
  logic [127:0] dout;
  logic         out_valid, in_ready, busy, ferr;

  // 32-bit / 8-bit-digit instance
  logic         start_s = 1'b0, in_valid_s = 1'b0, out_ready_s = 1'b1;
  logic [7:0]   d1_s = '0, d2_s = '0;
  logic [63:0]  dout_s;
  logic         out_valid_s, in_ready_s, busy_s, ferr_s;

  int n_tests = 0;
  int n_fail  = 0;
  int ferr_cnt = 0;

  kara_serial_mult #(.OP_W(64), .DIG_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .Data_in1(d1), .Data_in2(d2), .Data_out(dout), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .framing_err(ferr)
  );

  kara_serial_mult #(.OP_W(32), .DIG_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .Data_in1(d1_s), .Data_in2(d2_s), .Data_out(dout_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .busy(busy_s), .framing_err(ferr_s)
  );

  always @(posedge clk) if (ferr) ferr_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // send the first 'cnt' digits of a/b, MSB first, start on digit 0
  task automatic send64(input logic [63:0] a, input logic [63:0] b, input int cnt, input bit stall);
    for (int i = 0; i < cnt; i++) begin
      if (stall) begin
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          in_valid = 1'b0; start = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1;
      start    = (i == 0);
      d1       = a[63-4*i -: 4];
      d2       = b[63-4*i -: 4];
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      in_valid_s = 1'b1;
      start_s    = (i == 0);
      d1_s       = a[31-8*i -: 8];
      d2_s       = b[31-8*i -: 8];
      tick();
    end
    in_valid_s = 1'b0;
    start_s    = 1'b0;
  endtask

  // edges from the last-beat edge until out_valid; 0 if it never came
  task automatic wait_out(output int edges);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    edges = out_valid ? n : 0;
  endtask

  task automatic wait_out32(output int edges);
    int n;
    n = 0;
    while (!out_valid_s && n < 50) begin
      tick();
      n++;
    end
    edges = out_valid_s ? n : 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int lat;
    int fe0;
    logic [31:0] ra, rb;
    logic [63:0] exp_s;

    rst = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_data_out",  dout,      0);
    check("rst_ferr",      ferr,      0);
    rst = 1'b0;
    tick();

    // 1 x 1 with latency measurement
    out_ready = 1'b1;
    send64(64'h1, 64'h1, 16, 1'b0);
    wait_out(lat);
    check("lat_1x1", lat, 5);
    check("prod_1x1", dout, 128'h1);
    tick();
    check("hs_1x1_valid", out_valid, 0);
    check("hs_1x1_ready", in_ready, 1);

    // 2 x 3
    send64(64'h2, 64'h3, 16, 1'b0);
    wait_out(lat);
    check("prod_2x3", dout, 128'h6);
    tick();

    // all ones: middle sums carry into bit H
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1'b0);
    wait_out(lat);
    check("lat_ones", lat, 5);
    check("prod_ones", dout, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    tick();
    check("keep_after_hs", dout, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // input stalls plus output backpressure
    out_ready = 1'b0;
    send64(64'h1234, 64'h10, 16, 1'b1);
    wait_out(lat);
    check("prod_stall", dout, 128'h12340);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", dout, 128'h12340);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", out_valid, 0);
    check("bp_idle", busy, 0);

    // restart at digit 9 with a fresh full frame
    fe0 = ferr_cnt;
    send64(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 9, 1'b0);
    send64(64'hFF, 64'hFF, 16, 1'b0);
    wait_out(lat);
    check("lat_restart", lat, 5);
    check("prod_restart", dout, 128'hFE01);
    check("restart_no_ferr", ferr_cnt - fe0, 0);
    tick();

    // stray digit in IDLE
    fe0 = ferr_cnt;
    in_valid = 1'b1; start = 1'b0; d1 = 4'h5; d2 = 4'h7;
    tick();
    in_valid = 1'b0;
    check("stray_ferr", ferr, 1);
    check("stray_busy", busy, 0);
    check("stray_in_ready", in_ready, 1);
    tick();
    check("stray_ferr_pulse", ferr, 0);
    check("stray_ferr_count", ferr_cnt - fe0, 1);

    // reset during MUL_MID
    send64(64'h5, 64'h7, 16, 1'b0);
    tick(); tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    send64(64'h2, 64'h3, 16, 1'b0);
    wait_out(lat);
    check("prod_after_rst", dout, 128'h6);
    tick();

    // 32-bit / 8-bit variant
    out_ready_s = 1'b1;
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out32(lat);
    check("v32_lat", lat, 5);
    check("v32_ones", dout_s, 64'hFFFF_FFFE_0000_0001);
    tick();
    for (int f = 0; f < 200; f++) begin
      ra = $urandom();
      rb = $urandom();
      exp_s = {32'h0, ra} * {32'h0, rb};
      send32(ra, rb);
      wait_out32(lat);
      check("v32_rand", dout_s, exp_s);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kara_serial_mult.md
Name: kara_serial_mult

Overview:
- Parametrised successor to the fixed 64-bit nibble-serial Karatsuba multiplier.
- Deserialises two unsigned operands of OP_W bits, delivered DIG_W bits per accepted beat, most-significant digit first.
- Forms the 2*OP_W-bit product with one Karatsuba level using a single time-shared half-width multiplier.
- Adds the following, which the previous generation lacked: input stalls (in_valid/in_ready), output backpressure (out_valid/out_ready), restart-on-start, and framing-error reporting.

Parameters:
OP_W, 64, operand width in bits; must be a multiple of 2*DIG_W.
DIG_W, 4, digit width in bits per input beat; N = OP_W/DIG_W beats per frame.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  marks digit 0 of a frame; qualified by in_valid
in_valid  in  1  Data_in1/Data_in2 hold a valid digit this cycle
in_ready  out  1  block accepts digits (IDLE or COLLECT)
Data_in1  in  DIG_W  operand A digit, MSB-first
Data_in2  in  DIG_W  operand B digit, MSB-first
Data_out  out  2*OP_W  unsigned product A*B
out_valid  out  1  Data_out valid; held until out_ready
out_ready  in  1  consumer accepts Data_out
busy  out  1  high in any state other than IDLE
framing_err  out  1  one-cycle pulse on a dropped digit

Behaviour:
- All outputs and registers are reset by rst at a clock edge: Data_out=0, out_valid=0, busy=0, framing_err=0, in_ready=1, state=IDLE. rst overrides every other input, including mid-frame and mid-compute; partial results are discarded.
- Beat = a cycle with in_valid && in_ready.
- States: IDLE, COLLECT, MUL_LO, MUL_HI, MUL_MID, COMBINE, HOLD.
- IDLE:
  - Beat with start: shift the digit in, set digit count to 1, go to COLLECT. If N==1, go directly to MUL_LO.
  - Beat without start: drop the digit, pulse framing_err.
- COLLECT:
  - Beat without start: shift-left-insert the digit into both A and B; count++.
  - Beat with start: restart the frame. The new digit becomes digit 0 and count=1. No error is flagged.
  - Cycles with in_valid=0 are stalls; no state change.
  - When the beat carrying digit N-1 is accepted, go to MUL_LO.
- H = OP_W/2. aL/aH and bL/bH are the low/high halves of A and B.
- Sub-multiplier: unsigned (H+1)x(H+1) bits, result registered, 1-cycle latency.
  - MUL_LO issues aL*bL (z0).
  - MUL_HI issues aH*bH (z2).
  - MUL_MID issues (aL+aH)*(bL+bH) (zm). Both sums are H+1 bits.
- COMBINE:
  - z1 = zm - z0 - z2, computed in 2H+2 bits; the result is never negative.
  - Data_out <= (z2<<OP_W) + (z1<<H) + z0, truncated to 2*OP_W bits; the truncation is exact.
  - Go to HOLD with out_valid=1.
- Latency: out_valid is high 5 clock edges after the edge that accepts the last digit, with no backpressure.
- HOLD:
  - Data_out stays stable while out_valid=1 and out_ready=0.
  - When out_valid && out_ready: clear out_valid, go to IDLE.
  - out_ready=1 already in the first HOLD cycle is allowed; the transfer then completes in that cycle.
- in_ready=0 in MUL_LO through HOLD. Digits and start in those states are ignored and framing_err is not pulsed. A new frame is accepted from the cycle after the output handshake.
- Data_out keeps its last value after the handshake until the next COMBINE.

Decomposition:
- Package kara_pkg holds:
  - the state enum type;
  - localparams derived from OP_W/DIG_W (N, H, count width);
  - an elaboration-time check function asserting OP_W % (2*DIG_W) == 0.
- One sub-module, kara_half_mul: a parametrised (H+1)-bit unsigned multiplier with a registered output and a 1-cycle latency. The top module instantiates it once and time-shares it.

Test Plan:
- 1x1 (A=B=64'h1, 16 back-to-back beats, start on the first beat, out_ready=1) -> Data_out=128'h1; out_valid rises 5 edges after the last beat.
- 2x3, then A=B=64'hFFFF_FFFF_FFFF_FFFF -> 128'h6, then 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. This exercises the (H+1)-bit middle-sum carry.
- Input stalls: in_valid is deasserted for random gaps between digits of 64'h1234 x 64'h10 -> Data_out=128'h12340. out_ready held low for 7 cycles -> Data_out stable and out_valid held until out_ready.
- start reasserted at digit 9 of a frame, followed by a full 16-digit frame of 64'hFF x 64'hFF -> 128'hFE01. A stray in_valid without start in IDLE -> exactly one framing_err pulse, no state change.
- rst asserted during MUL_MID -> next edge shows out_valid=0, busy=0, in_ready=1. A following 2x3 frame -> 128'h6.
- Parameter variant OP_W=32, DIG_W=8 (4 beats): 32'hFFFF_FFFF squared -> 64'hFFFF_FFFE_0000_0001. Compare 200 random frames against a behavioural A*B model.
